// File: rtl/game_round_ctrl.sv
// Round controller for a code-breaking game: loads the secret, paces each
// guess through capture/score, tracks turns and reports win/loss.
module game_round_ctrl #(
    parameter int unsigned MAX_TURNS = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       new_game,
    input  logic       submit,
    input  logic [2:0] exact_cnt,
    input  logic [2:0] misplace_cnt,
    output logic       code_load,
    output logic       guess_load,
    output logic [3:0] turn,
    output logic [2:0] last_exact,
    output logic [2:0] last_misplace,
    output logic       playing,
    output logic       won,
    output logic       lost,
    output logic       score_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        CAPTURE,
        WAIT,
        SCORE,
        WON,
        LOST
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_TURNS);

    state_t     state_q, state_d;
    logic       ng_prev_q;
    logic       sub_prev_q;
    logic [3:0] turn_q, turn_d;
    logic [2:0] last_exact_q, last_exact_d;
    logic [2:0] last_misplace_q, last_misplace_d;
    logic       score_err_q, score_err_d;

    logic       ng_rise;
    logic       sub_rise;
    logic [3:0] score_sum;
    logic       score_bad;
    logic [3:0] turn_inc;

    always_comb begin
        ng_rise   = new_game & ~ng_prev_q;
        sub_rise  = submit & ~sub_prev_q;
        score_sum = {1'b0, exact_cnt} + {1'b0, misplace_cnt};
        score_bad = (exact_cnt > 3'd4) || (score_sum > 4'd4);
        turn_inc  = turn_q + 4'd1;
    end

    always_comb begin
        state_d         = state_q;
        turn_d          = turn_q;
        last_exact_d    = last_exact_q;
        last_misplace_d = last_misplace_q;
        score_err_d     = score_err_q;

        // A fresh new_game press restarts from any state, dropping a pending score
        if (ng_rise) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    turn_d          = 4'd0;
                    last_exact_d    = 3'd0;
                    last_misplace_d = 3'd0;
                    score_err_d     = 1'b0;
                    state_d         = PLAY;
                end
                PLAY: begin
                    if (sub_rise) state_d = CAPTURE;
                end
                CAPTURE: state_d = WAIT;
                WAIT:    state_d = SCORE;
                SCORE: begin
                    if (score_bad) begin
                        score_err_d = 1'b1;
                        state_d     = PLAY;
                    end else begin
                        last_exact_d    = exact_cnt;
                        last_misplace_d = misplace_cnt;
                        score_err_d     = 1'b0;
                        turn_d          = (turn_q >= MAX_T) ? MAX_T : turn_inc;
                        if (exact_cnt == 3'd4) state_d = WON;
                        else if (turn_inc == MAX_T) state_d = LOST;
                        else state_d = PLAY;
                    end
                end
                WON:     state_d = WON;
                LOST:    state_d = LOST;
                default: state_d = IDLE;
            endcase
        end
    end

    // Edge-detect history resets high so a level held through reset is not a press
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q         <= IDLE;
            ng_prev_q       <= 1'b1;
            sub_prev_q      <= 1'b1;
            turn_q          <= 4'd0;
            last_exact_q    <= 3'd0;
            last_misplace_q <= 3'd0;
            score_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ng_prev_q       <= new_game;
            sub_prev_q      <= submit;
            turn_q          <= turn_d;
            last_exact_q    <= last_exact_d;
            last_misplace_q <= last_misplace_d;
            score_err_q     <= score_err_d;
        end
    end

    always_comb begin
        code_load     = (state_q == LOAD);
        guess_load    = (state_q == CAPTURE);
        playing       = (state_q == PLAY) || (state_q == CAPTURE) ||
                        (state_q == WAIT) || (state_q == SCORE);
        won           = (state_q == WON);
        lost          = (state_q == LOST);
        turn          = turn_q;
        last_exact    = last_exact_q;
        last_misplace = last_misplace_q;
        score_err     = score_err_q;
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with a queue of expected
// post-score states built from a small game model.
module tb_game_round_ctrl;

    localparam int MT = 8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       new_game;
    logic       submit;
    logic [2:0] exact_cnt;
    logic [2:0] misplace_cnt;
    logic       code_load;
    logic       guess_load;
    logic [3:0] turn;
    logic [2:0] last_exact;
    logic [2:0] last_misplace;
    logic       playing;
    logic       won;
    logic       lost;
    logic       score_err;

    game_round_ctrl #(.MAX_TURNS(MT)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .new_game      (new_game),
        .submit        (submit),
        .exact_cnt     (exact_cnt),
        .misplace_cnt  (misplace_cnt),
        .code_load     (code_load),
        .guess_load    (guess_load),
        .turn          (turn),
        .last_exact    (last_exact),
        .last_misplace (last_misplace),
        .playing       (playing),
        .won           (won),
        .lost          (lost),
        .score_err     (score_err)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] turn;
        logic [2:0] le;
        logic [2:0] lm;
        logic       err;
        logic       won;
        logic       lost;
        logic       playing;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    logic [3:0] m_turn;
    logic [2:0] m_le;
    logic [2:0] m_lm;
    logic       m_err;
    logic       m_won;
    logic       m_lost;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_new();
        m_turn = 4'd0;
        m_le   = 3'd0;
        m_lm   = 3'd0;
        m_err  = 1'b0;
        m_won  = 1'b0;
        m_lost = 1'b0;
    endtask

    task automatic push_expect(input logic [2:0] e, input logic [2:0] m);
        exp_t x;
        if (int'(e) > 4 || int'(e) + int'(m) > 4) begin
            m_err = 1'b1;
        end else begin
            m_le  = e;
            m_lm  = m;
            m_err = 1'b0;
            if (int'(m_turn) < MT) m_turn = m_turn + 4'd1;
            if (e == 3'd4) m_won = 1'b1;
            else if (int'(m_turn) == MT) m_lost = 1'b1;
        end
        x.turn    = m_turn;
        x.le      = m_le;
        x.lm      = m_lm;
        x.err     = m_err;
        x.won     = m_won;
        x.lost    = m_lost;
        x.playing = !(m_won || m_lost);
        sb_q.push_back(x);
    endtask

    task automatic guess(input logic [2:0] e, input logic [2:0] m,
                         input string tag);
        exp_t x;
        exact_cnt    = 3'd7;
        misplace_cnt = 3'd7;
        push_expect(e, m);
        submit = 1'b1;
        tick();
        chk({tag, "/guess_load"}, 8'(guess_load), 8'd1);
        submit       = 1'b0;
        exact_cnt    = e;
        misplace_cnt = m;
        tick();
        chk({tag, "/gl_pulse"}, 8'(guess_load), 8'd0);
        tick();
        tick();
        x = sb_q.pop_front();
        chk({tag, "/turn"}, 8'(turn), 8'(x.turn));
        chk({tag, "/last_exact"}, 8'(last_exact), 8'(x.le));
        chk({tag, "/last_misplace"}, 8'(last_misplace), 8'(x.lm));
        chk({tag, "/score_err"}, 8'(score_err), 8'(x.err));
        chk({tag, "/won"}, 8'(won), 8'(x.won));
        chk({tag, "/lost"}, 8'(lost), 8'(x.lost));
        chk({tag, "/playing"}, 8'(playing), 8'(x.playing));
    endtask

    task automatic start_game(input string tag);
        new_game = 1'b1;
        tick();
        chk({tag, "/code_load"}, 8'(code_load), 8'd1);
        chk({tag, "/no_gl"}, 8'(guess_load), 8'd0);
        new_game = 1'b0;
        tick();
        chk({tag, "/code_load_1cyc"}, 8'(code_load), 8'd0);
        chk({tag, "/playing"}, 8'(playing), 8'd1);
        chk({tag, "/turn0"}, 8'(turn), 8'd0);
        chk({tag, "/le0"}, 8'(last_exact), 8'd0);
        chk({tag, "/err0"}, 8'(score_err), 8'd0);
        model_new();
    endtask

    task automatic ignored_submit(input string tag, input logic [3:0] t);
        submit = 1'b1;
        tick();
        chk({tag, "/no_gl"}, 8'(guess_load), 8'd0);
        submit = 1'b0;
        tick();
        chk({tag, "/no_gl2"}, 8'(guess_load), 8'd0);
        chk({tag, "/turn"}, 8'(turn), 8'(t));
    endtask

    initial begin
        Reset        = 1'b1;
        new_game     = 1'b1;
        submit       = 1'b1;
        exact_cnt    = 3'd0;
        misplace_cnt = 3'd0;
        model_new();
        repeat (3) tick();
        chk("rst/turn", 8'(turn), 8'd0);
        chk("rst/playing", 8'(playing), 8'd0);
        chk("rst/code_load", 8'(code_load), 8'd0);
        chk("rst/guess_load", 8'(guess_load), 8'd0);
        chk("rst/flags", {4'd0, won, lost, score_err, 1'b0}, 8'd0);
        chk("rst/last", {2'd0, last_exact, last_misplace}, 8'd0);

        // Levels held through reset must not count as presses
        Reset = 1'b0;
        tick();
        chk("held/code_load", 8'(code_load), 8'd0);
        tick();
        chk("held/playing", 8'(playing), 8'd0);
        new_game = 1'b0;
        submit   = 1'b0;
        tick();
        chk("idle/still", 8'(playing), 8'd0);

        start_game("g1");
        guess(3'd2, 3'd1, "g1_t1");
        guess(3'd3, 3'd3, "g1_bad_sum");
        guess(3'd5, 3'd0, "g1_bad_exact");
        guess(3'd1, 3'd2, "g1_t2");
        for (int i = 3; i <= MT; i++) guess(3'd1, 3'd0, "g1_miss");
        chk("g1/lost", 8'(lost), 8'd1);
        ignored_submit("g1_after_lost", 4'd8);
        chk("g1/lost_held", 8'(lost), 8'd1);

        start_game("g2");
        for (int i = 1; i < MT; i++) guess(3'd0, 3'd1, "g2_miss");
        guess(3'd4, 3'd0, "g2_win_last");
        ignored_submit("g2_after_won", 4'd8);
        chk("g2/won_held", 8'(won), 8'd1);

        start_game("g3");
        guess(3'd3, 3'd3, "g3_bad");
        new_game = 1'b1;
        submit   = 1'b1;
        tick();
        chk("both/code_load", 8'(code_load), 8'd1);
        chk("both/no_gl", 8'(guess_load), 8'd0);
        new_game = 1'b0;
        submit   = 1'b0;
        tick();
        chk("both/no_gl2", 8'(guess_load), 8'd0);
        chk("both/err_clr", 8'(score_err), 8'd0);
        tick();
        chk("both/no_gl3", 8'(guess_load), 8'd0);
        chk("both/playing", 8'(playing), 8'd1);
        model_new();

        guess(3'd2, 3'd1, "g3_t1");
        submit = 1'b1;
        tick();
        chk("abandon/gl", 8'(guess_load), 8'd1);
        submit       = 1'b0;
        exact_cnt    = 3'd2;
        misplace_cnt = 3'd1;
        tick();
        new_game = 1'b1;
        tick();
        chk("abandon/code_load", 8'(code_load), 8'd1);
        new_game = 1'b0;
        tick();
        chk("abandon/turn", 8'(turn), 8'd0);
        chk("abandon/le", 8'(last_exact), 8'd0);
        chk("abandon/no_gl", 8'(guess_load), 8'd0);
        model_new();

        guess(3'd1, 3'd1, "g4_t1");
        Reset    = 1'b1;
        new_game = 1'b1;
        tick();
        chk("rst_pri/playing", 8'(playing), 8'd0);
        chk("rst_pri/code_load", 8'(code_load), 8'd0);
        chk("rst_pri/turn", 8'(turn), 8'd0);
        Reset    = 1'b0;
        new_game = 1'b0;
        tick();

        chk("sb/empty", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_TURNS, default 8, range 1..15: number of guesses allowed per game.
REQ-002 SHALL have port Clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port new_game, input, 1 bit: level request to start a game (inverted KEY[1]).
REQ-005 SHALL have port submit, input, 1 bit: level request to score the current guess (inverted KEY[0]).
REQ-006 SHALL have port exact_cnt, input, 3 bits: right-colour, right-position count, 0..4, valid one cycle after guess_load.
REQ-007 SHALL have port misplace_cnt, input, 3 bits: right-colour, wrong-position count, 0..4, valid one cycle after guess_load.
REQ-008 SHALL have port code_load, output, 1 bit: one-cycle pulse that loads the secret-code registers.
REQ-009 SHALL have port guess_load, output, 1 bit: one-cycle pulse that captures the switch guess into the guess registers.
REQ-010 SHALL have port turn, output, 4 bits: guesses scored in the current game.
REQ-011 SHALL have ports last_exact and last_misplace, output, 3 bits each: registered scores of the most recent accepted guess.
REQ-012 SHALL have ports playing, won, lost and score_err, output, 1 bit each: game status flags.

Function
REQ-013 SHALL detect a rise on new_game and on submit as input=1 in the current cycle with a registered previous value of 0.
REQ-014 SHALL implement Moore FSM states IDLE, LOAD, PLAY, CAPTURE, WAIT, SCORE, WON and LOST.
REQ-015 SHALL transition IDLE->LOAD on a new_game rise; in IDLE, submit is ignored.
REQ-016 SHALL spend exactly one cycle in LOAD, asserting code_load, clearing turn, last_exact, last_misplace and score_err, then go to PLAY.
REQ-017 SHALL transition PLAY->CAPTURE on a submit rise, with playing=1 throughout PLAY, CAPTURE, WAIT and SCORE.
REQ-018 SHALL assert guess_load only in CAPTURE, for one cycle, then go to WAIT; WAIT lasts one cycle, then SCORE.
REQ-019 SHALL sample exact_cnt and misplace_cnt at the end of the SCORE cycle, with updated outputs visible the next cycle.
   - Latency: submit rise sampled in cycle k -> guess_load in k+1 -> sample in k+3 -> new turn/last_* in k+4.
REQ-020 SHALL reject a SCORE sample with exact_cnt>4 or exact_cnt+misplace_cnt>4:
   - score_err=1 (held until the next accepted score or LOAD);
   - turn and last_* unchanged;
   - return to PLAY.
REQ-021 SHALL, on an accepted sample:
   - update last_exact and last_misplace;
   - increment turn, saturating at MAX_TURNS;
   - clear score_err.
REQ-022 SHALL select the next state after an accepted sample as:
   - exact_cnt==4 -> WON; this takes priority, including on the final turn;
   - otherwise turn+1==MAX_TURNS -> LOST;
   - otherwise -> PLAY.
REQ-023 SHALL hold won=1 in WON and lost=1 in LOST, with all outputs frozen and submit ignored until a new_game rise -> LOAD.
REQ-024 SHALL restart to LOAD on a new_game rise in any state other than IDLE/WON/LOST, abandoning any in-progress score with no guess_load or sample.
REQ-025 SHALL give new_game priority when new_game and submit rises occur in the same cycle.
REQ-026 SHALL require submit or new_game to return to 0 and rise again before a held level is accepted a second time.

Reset
REQ-027 SHALL, on Reset=1 at a clock edge, set state IDLE, turn=0, last_exact=0, last_misplace=0, all flags and pulses 0, regardless of state.
REQ-028 SHALL reset both previous-value registers to 1, so an input held high through reset is not a rise until it is released and pressed again.
REQ-029 SHALL take Reset priority over every other input in the same cycle.

Verification
REQ-030 SHALL be verified by these directed scenarios:
   - Reset, then a new_game pulse -> code_load=1 for exactly 1 cycle; then playing=1, turn=0.
   - submit rise in cycle k, with exact=2 and misplace=1 presented at k+2 -> guess_load at k+1; at k+4 turn=1, last_exact=2, last_misplace=1.
   - MAX_TURNS=8, eight submits all exact=1 -> after the 8th, lost=1, turn=8; a further submit leaves turn at 8 with no guess_load.
   - Submit with exact=4 on turn 8 -> won=1, lost=0, turn=8.
   - Submit with exact=3 and misplace=3 -> score_err=1, turn unchanged, playing=1; next valid submit clears score_err.
   - submit held high through Reset, then released, then new_game; new_game and submit rising together in PLAY -> no capture from the held submit; LOAD taken with no guess_load.
